// File: rtl/gpu_pkg.sv
// gpu_pkg
// Shared definitions for the per-core thread register bank.
//   wr_src_e          : writeback source selector encoding
//   OFF_BLOCK_ID ..   : distance of each special read-only register from
//                       the top of a thread's register file
//   NUM_SPECIAL       : number of read-only registers at the top of the file
package gpu_pkg;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_IMM  = 2'd1,
        WB_RSV2 = 2'd2,
        WB_RSV3 = 2'd3
    } wr_src_e;

    localparam int OFF_BLOCK_ID  = 3;
    localparam int OFF_BLOCK_DIM = 2;
    localparam int OFF_THREAD_ID = 1;
    localparam int NUM_SPECIAL   = 3;

endpackage

// File: rtl/load_scoreboard.sv
// load_scoreboard
// Tracks one pending-load bit per (thread slot, register) and turns it into
// the scheduler-facing hazard, the per-lane pending summary and the sticky
// writeback-conflict flag.
//   clk, reset     : core clock, asynchronous active-low reset
//   thread_enable  : lane active mask (gates hazard and load issue)
//   rs/rt/wr_addr  : addresses checked for hazards; wr_addr is also the
//                    destination marked pending on ld_issue
//   ld_issue       : marks wr_addr pending on enabled lanes
//   lane_wr        : per-lane ALU/immediate write actually happening this cycle
//   lsu_valid/addr : per-lane load return, clears the addressed bit
//   hazard         : any enabled lane reads or writes a pending register
//   pending        : per-lane OR of all pending bits
//   wb_conflict    : sticky; LSU return clashed with a writeback or hit a
//                    register that was not waiting on a load
module load_scoreboard #(
    parameter int THREADS   = 4,
    parameter int NUM_REGS  = 16,
    parameter int ADDR_BITS = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [THREADS-1:0]             thread_enable,
    input  logic [ADDR_BITS-1:0]           rs_addr,
    input  logic [ADDR_BITS-1:0]           rt_addr,
    input  logic [ADDR_BITS-1:0]           wr_addr,
    input  logic                           ld_issue,
    input  logic [THREADS-1:0]             lane_wr,
    input  logic [THREADS-1:0]             lsu_valid,
    input  logic [THREADS*ADDR_BITS-1:0]   lsu_addr,
    output logic                           hazard,
    output logic [THREADS-1:0]             pending,
    output logic                           wb_conflict
);
    import gpu_pkg::*;

    localparam logic [ADDR_BITS-1:0] RO_BASE = ADDR_BITS'(NUM_REGS - NUM_SPECIAL);

    logic [NUM_REGS-1:0] pend_q [THREADS];
    logic [NUM_REGS-1:0] pend_d [THREADS];
    logic                conflict_now;

    // Next pending state: a load return clears its bit, then a new issue
    // sets it, so an issue in the same cycle as a return to the same
    // register leaves the bit set. Conflict is judged on the pre-edge state.
    always_comb begin
        conflict_now = 1'b0;
        for (int t = 0; t < THREADS; t++) begin
            pend_d[t] = pend_q[t];
            if (lsu_valid[t]) begin
                if (!pend_q[t][lsu_addr[t*ADDR_BITS +: ADDR_BITS]]) begin
                    conflict_now = 1'b1;
                end
                if (lane_wr[t] && (wr_addr == lsu_addr[t*ADDR_BITS +: ADDR_BITS])) begin
                    conflict_now = 1'b1;
                end
                pend_d[t][lsu_addr[t*ADDR_BITS +: ADDR_BITS]] = 1'b0;
            end
            if (ld_issue && thread_enable[t] && (wr_addr < RO_BASE)) begin
                pend_d[t][wr_addr] = 1'b1;
            end
        end
    end

    // Pending bits and the sticky conflict flag; only reset clears the flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int t = 0; t < THREADS; t++) begin
                pend_q[t] <= '0;
            end
            wb_conflict <= 1'b0;
        end else begin
            for (int t = 0; t < THREADS; t++) begin
                pend_q[t] <= pend_d[t];
            end
            wb_conflict <= wb_conflict | conflict_now;
        end
    end

    // Hazard is combinational from the registered bits; disabled lanes
    // do not stall the scheduler even if they have loads outstanding.
    always_comb begin
        hazard = 1'b0;
        for (int t = 0; t < THREADS; t++) begin
            pending[t] = |pend_q[t];
            if (thread_enable[t]) begin
                hazard = hazard | pend_q[t][rs_addr] | pend_q[t][rt_addr] | pend_q[t][wr_addr];
            end
        end
    end

endmodule

// File: rtl/thread_register_bank.sv
// thread_register_bank
// Register file for every thread slot of a core. Reads share one address
// across all lanes (SIMT); writeback comes from the ALU, a broadcast
// immediate, or per-lane load returns. The top NUM_SPECIAL registers of each
// lane are read-only: block_id, block_dim and the lane index.
//   clk, reset          : core clock, asynchronous active-low reset
//   block_id, block_dim : block context, re-registered every cycle
//   thread_enable       : lane active mask
//   rs/rt_addr, *_data  : shared read addresses, packed lane data (lane 0 LSBs)
//   wr_en, wr_addr,
//   wr_src, alu_result,
//   immediate           : writeback strobe, destination, source, operands
//   ld_issue            : marks wr_addr as awaiting a load
//   lsu_valid/addr/data : per-lane load return
//   hazard, pending,
//   wb_conflict         : scoreboard outputs to the scheduler
module thread_register_bank #(
    parameter int   THREADS   = 4,
    parameter int   NUM_REGS  = 16,
    parameter int   DATA_BITS = 8,
    localparam int  ADDR_BITS = $clog2(NUM_REGS)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [7:0]                     block_id,
    input  logic [7:0]                     block_dim,
    input  logic [THREADS-1:0]             thread_enable,
    input  logic [ADDR_BITS-1:0]           rs_addr,
    input  logic [ADDR_BITS-1:0]           rt_addr,
    output logic [THREADS*DATA_BITS-1:0]   rs_data,
    output logic [THREADS*DATA_BITS-1:0]   rt_data,
    input  logic                           wr_en,
    input  logic [ADDR_BITS-1:0]           wr_addr,
    input  logic [1:0]                     wr_src,
    input  logic [THREADS*DATA_BITS-1:0]   alu_result,
    input  logic [DATA_BITS-1:0]           immediate,
    input  logic                           ld_issue,
    input  logic [THREADS-1:0]             lsu_valid,
    input  logic [THREADS*ADDR_BITS-1:0]   lsu_addr,
    input  logic [THREADS*DATA_BITS-1:0]   lsu_data,
    output logic                           hazard,
    output logic [THREADS-1:0]             pending,
    output logic                           wb_conflict
);
    import gpu_pkg::*;

    localparam logic [ADDR_BITS-1:0] RO_BASE = ADDR_BITS'(NUM_REGS - NUM_SPECIAL);

    logic [DATA_BITS-1:0] regs      [THREADS][NUM_REGS];
    logic [DATA_BITS-1:0] view      [THREADS][NUM_REGS];
    logic [DATA_BITS-1:0] wb_value  [THREADS];
    logic [DATA_BITS-1:0] block_id_q;
    logic [DATA_BITS-1:0] block_dim_q;
    logic [THREADS-1:0]   lane_wr;
    logic                 src_writes;

    // ALU/immediate writeback per lane. A load issue in the same cycle takes
    // the slot, reserved sources write nothing, and read-only targets drop.
    always_comb begin
        src_writes = (wr_src == WB_ALU) || (wr_src == WB_IMM);
        for (int t = 0; t < THREADS; t++) begin
            lane_wr[t]  = wr_en && !ld_issue && src_writes && thread_enable[t]
                          && (wr_addr < RO_BASE);
            wb_value[t] = (wr_src == WB_IMM) ? immediate
                                             : alu_result[t*DATA_BITS +: DATA_BITS];
        end
    end

    // Register storage. The LSU assignment comes last so it overrides an
    // ALU/immediate write to the same lane and register in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            block_id_q  <= '0;
            block_dim_q <= '0;
            for (int t = 0; t < THREADS; t++) begin
                for (int r = 0; r < NUM_REGS; r++) begin
                    regs[t][r] <= '0;
                end
            end
        end else begin
            block_id_q  <= DATA_BITS'(block_id);
            block_dim_q <= DATA_BITS'(block_dim);
            for (int t = 0; t < THREADS; t++) begin
                if (lane_wr[t]) begin
                    regs[t][wr_addr] <= wb_value[t];
                end
                if (lsu_valid[t] && (lsu_addr[t*ADDR_BITS +: ADDR_BITS] < RO_BASE)) begin
                    regs[t][lsu_addr[t*ADDR_BITS +: ADDR_BITS]] <= lsu_data[t*DATA_BITS +: DATA_BITS];
                end
            end
        end
    end

    // Architectural view of each lane's file with the special registers
    // overlaid on the top entries.
    always_comb begin
        for (int t = 0; t < THREADS; t++) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                view[t][r] = regs[t][r];
            end
            view[t][NUM_REGS-OFF_BLOCK_ID]  = block_id_q;
            view[t][NUM_REGS-OFF_BLOCK_DIM] = block_dim_q;
            view[t][NUM_REGS-OFF_THREAD_ID] = DATA_BITS'(t);
        end
    end

    // Shared-address reads with no write bypass; disabled lanes still read.
    always_comb begin
        for (int t = 0; t < THREADS; t++) begin
            rs_data[t*DATA_BITS +: DATA_BITS] = view[t][rs_addr];
            rt_data[t*DATA_BITS +: DATA_BITS] = view[t][rt_addr];
        end
    end

    load_scoreboard #(
        .THREADS   (THREADS),
        .NUM_REGS  (NUM_REGS),
        .ADDR_BITS (ADDR_BITS)
    ) u_scoreboard (
        .clk           (clk),
        .reset         (reset),
        .thread_enable (thread_enable),
        .rs_addr       (rs_addr),
        .rt_addr       (rt_addr),
        .wr_addr       (wr_addr),
        .ld_issue      (ld_issue),
        .lane_wr       (lane_wr),
        .lsu_valid     (lsu_valid),
        .lsu_addr      (lsu_addr),
        .hazard        (hazard),
        .pending       (pending),
        .wb_conflict   (wb_conflict)
    );

endmodule

// File: tb/tb_thread_register_bank.sv
// tb_thread_register_bank
// Self-checking bench for thread_register_bank with its default parameters
// (4 lanes, 16 registers, 8-bit data). A behavioural model of the register
// file and load scoreboard is advanced once per clock; expected values are
// queued when stimulus is applied and compared against the DUT afterwards.
module tb_thread_register_bank;

    localparam int TH = 4;
    localparam int NR = 16;
    localparam int DB = 8;
    localparam int AB = 4;

    logic              clk;
    logic              reset;
    logic [7:0]        block_id;
    logic [7:0]        block_dim;
    logic [TH-1:0]     thread_enable;
    logic [AB-1:0]     rs_addr;
    logic [AB-1:0]     rt_addr;
    logic [TH*DB-1:0]  rs_data;
    logic [TH*DB-1:0]  rt_data;
    logic              wr_en;
    logic [AB-1:0]     wr_addr;
    logic [1:0]        wr_src;
    logic [TH*DB-1:0]  alu_result;
    logic [DB-1:0]     immediate;
    logic              ld_issue;
    logic [TH-1:0]     lsu_valid;
    logic [TH*AB-1:0]  lsu_addr;
    logic [TH*DB-1:0]  lsu_data;
    logic              hazard;
    logic [TH-1:0]     pending;
    logic              wb_conflict;

    thread_register_bank #(
        .THREADS   (TH),
        .NUM_REGS  (NR),
        .DATA_BITS (DB)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .block_id      (block_id),
        .block_dim     (block_dim),
        .thread_enable (thread_enable),
        .rs_addr       (rs_addr),
        .rt_addr       (rt_addr),
        .rs_data       (rs_data),
        .rt_data       (rt_data),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_src        (wr_src),
        .alu_result    (alu_result),
        .immediate     (immediate),
        .ld_issue      (ld_issue),
        .lsu_valid     (lsu_valid),
        .lsu_addr      (lsu_addr),
        .lsu_data      (lsu_data),
        .hazard        (hazard),
        .pending       (pending),
        .wb_conflict   (wb_conflict)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    int tests_run    = 0;
    int tests_failed = 0;

    // Kinds of observation the scoreboard can request.
    localparam int K_RS  = 0;
    localparam int K_RT  = 1;
    localparam int K_HAZ = 2;
    localparam int K_PND = 3;
    localparam int K_CON = 4;

    typedef struct {
        string       tag;
        int          kind;
        int          lane;
        logic [31:0] expv;
    } exp_t;

    exp_t sb_q[$];

    // Reference model state.
    logic [7:0] m_regs [TH][NR];
    bit         m_pend [TH][NR];
    bit         m_conf;
    logic [7:0] m_bid;
    logic [7:0] m_bdim;

    task automatic modelReset();
        for (int t = 0; t < TH; t++) begin
            for (int r = 0; r < NR; r++) begin
                m_regs[t][r] = 8'h00;
                m_pend[t][r] = 1'b0;
            end
        end
        m_conf = 1'b0;
        m_bid  = 8'h00;
        m_bdim = 8'h00;
    endtask

    function automatic logic [7:0] modelRead(int lane, int a);
        if (a == 13) return m_bid;
        if (a == 14) return m_bdim;
        if (a == 15) return 8'(lane);
        return m_regs[lane][a];
    endfunction

    function automatic logic modelHazard();
        logic h = 1'b0;
        for (int t = 0; t < TH; t++) begin
            if (thread_enable[t] && (m_pend[t][rs_addr] || m_pend[t][rt_addr] || m_pend[t][wr_addr]))
                h = 1'b1;
        end
        return h;
    endfunction

    function automatic logic [TH-1:0] modelPending();
        logic [TH-1:0] p = '0;
        for (int t = 0; t < TH; t++) begin
            for (int r = 0; r < NR; r++) begin
                if (m_pend[t][r]) p[t] = 1'b1;
            end
        end
        return p;
    endfunction

    // Effect of one rising edge with the currently driven inputs.
    task automatic modelEdge();
        logic [7:0] nregs [TH][NR];
        bit         npend [TH][NR];
        bit         alu_wr;
        int         la;
        for (int t = 0; t < TH; t++) begin
            for (int r = 0; r < NR; r++) begin
                nregs[t][r] = m_regs[t][r];
                npend[t][r] = m_pend[t][r];
            end
        end
        for (int t = 0; t < TH; t++) begin
            la     = int'(lsu_addr[t*AB +: AB]);
            alu_wr = wr_en && !ld_issue && (wr_src <= 2'd1) && thread_enable[t] && (wr_addr < 13);
            if (alu_wr)
                nregs[t][wr_addr] = (wr_src == 2'd1) ? immediate : alu_result[t*DB +: DB];
            if (lsu_valid[t]) begin
                if (la < 13) nregs[t][la] = lsu_data[t*DB +: DB];
                if (!m_pend[t][la] || (alu_wr && (la == int'(wr_addr)))) m_conf = 1'b1;
                npend[t][la] = 1'b0;
            end
            if (ld_issue && thread_enable[t] && (wr_addr < 13))
                npend[t][wr_addr] = 1'b1;
        end
        for (int t = 0; t < TH; t++) begin
            for (int r = 0; r < NR; r++) begin
                m_regs[t][r] = nregs[t][r];
                m_pend[t][r] = npend[t][r];
            end
        end
        m_bid  = block_id;
        m_bdim = block_dim;
    endtask

    task automatic checkOutput(string tag, logic [31:0] actual, logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Queue an expectation derived from the model and the current inputs.
    task automatic pushExpect(string tag, int kind, int lane);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.lane = lane;
        case (kind)
            K_RS:    e.expv = 32'(modelRead(lane, int'(rs_addr)));
            K_RT:    e.expv = 32'(modelRead(lane, int'(rt_addr)));
            K_HAZ:   e.expv = 32'(modelHazard());
            K_PND:   e.expv = 32'(modelPending());
            default: e.expv = 32'(m_conf);
        endcase
        sb_q.push_back(e);
    endtask

    // Let combinational outputs settle, then compare everything queued.
    task automatic settle();
        exp_t        e;
        logic [31:0] actual;
        #1;
        while (sb_q.size() > 0) begin
            e      = sb_q.pop_front();
            actual = '0;
            case (e.kind)
                K_RS:    actual[7:0] = rs_data[e.lane*DB +: DB];
                K_RT:    actual[7:0] = rt_data[e.lane*DB +: DB];
                K_HAZ:   actual[0]   = hazard;
                K_PND:   actual[3:0] = pending;
                default: actual[0]   = wb_conflict;
            endcase
            checkOutput(e.tag, actual, e.expv);
        end
    endtask

    // One clock edge; inputs are then free to change one unit after it.
    task automatic applyStimulus();
        modelEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        thread_enable = 4'hF;
        wr_en         = 1'b0;
        wr_addr       = '0;
        wr_src        = 2'd0;
        alu_result    = '0;
        immediate     = '0;
        ld_issue      = 1'b0;
        lsu_valid     = '0;
        lsu_addr      = '0;
        lsu_data      = '0;
    endtask

    task automatic expectAllLanes(string tag, int kind);
        for (int l = 0; l < TH; l++) pushExpect($sformatf("%s_l%0d", tag, l), kind, l);
    endtask

    initial begin
        reset     = 1'b0;
        block_id  = 8'd5;
        block_dim = 8'd4;
        rs_addr   = '0;
        rt_addr   = '0;
        idle();
        modelReset();
        repeat (2) @(posedge clk);
        #1;

        // Reset state: specials show lane index / 0 / 0, scoreboard quiet.
        rs_addr = 4'd15;
        rt_addr = 4'd13;
        pushExpect("rst_r15_l2", K_RS, 2);
        pushExpect("rst_r13_l2", K_RT, 2);
        pushExpect("rst_hazard", K_HAZ, 0);
        pushExpect("rst_pending", K_PND, 0);
        pushExpect("rst_conflict", K_CON, 0);
        settle();
        reset = 1'b1;
        applyStimulus();

        // First clock after release loads block_id/block_dim.
        rs_addr = 4'd13;
        rt_addr = 4'd14;
        pushExpect("bid_l2", K_RS, 2);
        pushExpect("bdim_l2", K_RT, 2);
        settle();
        rs_addr = 4'd15;
        pushExpect("tid_l2", K_RS, 2);
        pushExpect("tid_l0", K_RS, 0);
        settle();
        for (int a = 0; a <= 12; a++) begin
            rs_addr = 4'(a);
            rt_addr = 4'(a);
            pushExpect($sformatf("zero_r%0d_l2", a), K_RS, 2);
            pushExpect($sformatf("zero_r%0d_l0", a), K_RT, 0);
            settle();
            applyStimulus();
        end

        // block_id change is visible one cycle later.
        block_id = 8'd9;
        rs_addr  = 4'd13;
        pushExpect("bid_before", K_RS, 1);
        settle();
        applyStimulus();
        pushExpect("bid_after", K_RS, 1);
        settle();

        // ALU writeback with a partial lane mask; same-cycle read sees old value.
        wr_en         = 1'b1;
        wr_addr       = 4'd3;
        wr_src        = 2'd0;
        alu_result    = 32'h44332211;
        thread_enable = 4'b0101;
        rs_addr       = 4'd3;
        pushExpect("r3_nobypass_l0", K_RS, 0);
        settle();
        applyStimulus();
        idle();
        expectAllLanes("r3_alu", K_RS);
        settle();

        // Immediate to a read-only register is dropped; to R5 it lands.
        wr_en     = 1'b1;
        wr_src    = 2'd1;
        wr_addr   = 4'd14;
        immediate = 8'hFF;
        applyStimulus();
        idle();
        rs_addr = 4'd14;
        expectAllLanes("r14_ro", K_RS);
        settle();
        wr_en     = 1'b1;
        wr_src    = 2'd1;
        wr_addr   = 4'd5;
        immediate = 8'h5A;
        applyStimulus();
        // Reserved source must not write.
        wr_en      = 1'b1;
        wr_src     = 2'd2;
        wr_addr    = 4'd5;
        alu_result = 32'h99999999;
        applyStimulus();
        idle();
        rs_addr = 4'd5;
        expectAllLanes("r5_imm", K_RS);
        settle();

        // Load to R7 on all lanes; a same-cycle wr_en loses to ld_issue.
        ld_issue   = 1'b1;
        wr_en      = 1'b1;
        wr_src     = 2'd0;
        wr_addr    = 4'd7;
        alu_result = 32'hEEEEEEEE;
        applyStimulus();
        idle();
        rs_addr = 4'd7;
        pushExpect("ld_hazard", K_HAZ, 0);
        pushExpect("ld_pending", K_PND, 0);
        expectAllLanes("r7_ldwins", K_RS);
        settle();
        for (int i = 0; i < TH; i++) begin
            lsu_valid = 4'(1 << i);
            lsu_addr  = 16'h7777;
            lsu_data  = 32'hA3A2A1A0;
            applyStimulus();
            idle();
            rs_addr = 4'd7;
            pushExpect($sformatf("ret%0d_hazard", i), K_HAZ, 0);
            pushExpect($sformatf("ret%0d_pending", i), K_PND, 0);
            settle();
            if (i == 1) begin
                // Only lanes with nothing outstanding enabled: no stall.
                thread_enable = 4'b0011;
                pushExpect("masked_hazard", K_HAZ, 0);
                settle();
                thread_enable = 4'hF;
            end
        end
        expectAllLanes("r7_lsu", K_RS);
        pushExpect("ret_conflict", K_CON, 0);
        settle();

        // LSU return and ALU writeback to the same lane/register.
        thread_enable = 4'b0010;
        ld_issue      = 1'b1;
        wr_addr       = 4'd7;
        applyStimulus();
        idle();
        wr_en      = 1'b1;
        wr_src     = 2'd0;
        wr_addr    = 4'd7;
        alu_result = 32'hC3C2C1C0;
        lsu_valid  = 4'b0010;
        lsu_addr   = 16'h0070;
        lsu_data   = 32'h0000B100;
        pushExpect("clash_conflict_pre", K_CON, 0);
        settle();
        applyStimulus();
        idle();
        rs_addr = 4'd7;
        expectAllLanes("r7_clash", K_RS);
        pushExpect("clash_conflict", K_CON, 0);
        settle();
        repeat (3) applyStimulus();
        pushExpect("conflict_sticky", K_CON, 0);
        settle();

        // Two loads outstanding, then asynchronous reset mid-cycle.
        thread_enable = 4'b0001;
        ld_issue      = 1'b1;
        wr_addr       = 4'd9;
        applyStimulus();
        idle();
        thread_enable = 4'b0010;
        ld_issue      = 1'b1;
        wr_addr       = 4'd10;
        applyStimulus();
        idle();
        rs_addr = 4'd9;
        pushExpect("two_pending", K_PND, 0);
        pushExpect("two_hazard", K_HAZ, 0);
        settle();
        #2;
        reset = 1'b0;
        modelReset();
        rs_addr = 4'd3;
        rt_addr = 4'd13;
        pushExpect("arst_pending", K_PND, 0);
        pushExpect("arst_hazard", K_HAZ, 0);
        pushExpect("arst_conflict", K_CON, 0);
        pushExpect("arst_r3_l0", K_RS, 0);
        pushExpect("arst_r13_l0", K_RT, 0);
        settle();
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Late load return after reset writes and flags a conflict.
        lsu_valid = 4'b0001;
        lsu_addr  = 16'h0009;
        lsu_data  = 32'h00000077;
        applyStimulus();
        idle();
        rs_addr = 4'd9;
        pushExpect("late_r9_l0", K_RS, 0);
        pushExpect("late_conflict", K_CON, 0);
        pushExpect("late_pending", K_PND, 0);
        settle();

        // Issue and return to the same bit in one cycle: set wins, data lands.
        thread_enable = 4'b0100;
        ld_issue      = 1'b1;
        wr_addr       = 4'd4;
        lsu_valid     = 4'b0100;
        lsu_addr      = 16'h0400;
        lsu_data      = 32'h00990000;
        applyStimulus();
        idle();
        rs_addr = 4'd4;
        pushExpect("setwin_r4_l2", K_RS, 2);
        pushExpect("setwin_pending", K_PND, 0);
        pushExpect("setwin_hazard", K_HAZ, 0);
        settle();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
